// File: rtl/uart_pkg.sv
// Shared UART definitions used by the feeder, transmitter and receiver.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read (no read-ahead register); one cycle push-to-visible.
// Pushes while full and pops while empty are ignored; full/empty come from the registered count.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system bytes and launches them one at a time into the UART transmitter; start rises two edges after a push into an idle empty feeder.
// Pops only from IDLE with tx_busy low; a full FIFO drops pushes and sets overflow; a watchdog aborts a frame that never completes.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_W  = UART_DATA_W,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 65535,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              start,
  output logic [DATA_W-1:0] data_out,
  output logic              overflow,
  output logic              tx_err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  feeder_state_t     state;
  logic [WD_W-1:0]   wd;
  logic              launch;
  logic [DATA_W-1:0] head;

  assign launch = (state == IDLE) && !empty && !tx_busy;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk1),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (launch),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state    <= IDLE;
      start    <= 1'b0;
      data_out <= '0;
      wd       <= '0;
      overflow <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      // Full is sampled from the registered count, so a same-cycle pop never rescues the push.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            data_out <= head;
            start    <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          wd    <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            state <= IDLE;
          end else if (wd == WD_LAST) begin
            tx_err <= 1'b1;
            state  <= IDLE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised and directed checks of uart_tx_feeder against a queue-based reference model.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;

  logic       full, empty, start, overflow, tx_err;
  logic [4:0] count;
  logic [7:0] data_out;

  logic       full2, empty2, start2, overflow2, tx_err2;
  logic [4:0] count2;
  logic [7:0] data_out2;

  always #5 clk1 = ~clk1;

  uart_tx_feeder #(.DATA_W(8), .DEPTH(DEPTH), .TIMEOUT(65535)) dut (
    .clk1(clk1), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count),
    .tx_busy(tx_busy), .tx_done(tx_done), .start(start), .data_out(data_out),
    .overflow(overflow), .tx_err(tx_err)
  );

  // Short-watchdog instance whose transmitter never completes a frame.
  uart_tx_feeder #(.DATA_W(8), .DEPTH(DEPTH), .TIMEOUT(50)) dut_wd (
    .clk1(clk1), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full2), .empty(empty2), .count(count2),
    .tx_busy(tx_busy), .tx_done(1'b0), .start(start2), .data_out(data_out2),
    .overflow(overflow2), .tx_err(tx_err2)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: queue contents, launch phase (0 idle, 1 launching, 2 awaiting completion).
  logic [7:0] q[$];
  int         phase = 0;
  bit         m_ovf = 1'b0;
  bit         exp_start = 1'b0;
  logic [7:0] exp_data = 8'h00;

  task automatic cycle(input bit we, input logic [7:0] d, input bit busy, input bit done);
    bit pop;
    bit push_ok;
    @(negedge clk1);
    wr_en = we; wr_data = d; tx_busy = busy; tx_done = done;
    push_ok = we && (q.size() < DEPTH);
    if (we && !push_ok) m_ovf = 1'b1;
    pop = (phase == 0) && (q.size() > 0) && !busy;
    case (phase)
      0: if (pop) begin exp_data = q.pop_front(); phase = 1; end
      1: phase = 2;
      default: if (done) phase = 0;
    endcase
    if (push_ok) q.push_back(d);
    exp_start = pop;
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset(input int n, input bit we);
    @(negedge clk1);
    rst = 1'b1; wr_en = we; wr_data = 8'hA5; tx_busy = 1'b0; tx_done = 1'b0;
    repeat (n) @(posedge clk1);
    @(negedge clk1);
    rst = 1'b0; wr_en = 1'b0;
    q.delete(); phase = 0; m_ovf = 1'b0; exp_start = 1'b0;
  endtask

  // Drives npush bytes through the feeder with a transmitter model, then drains.
  task automatic drive_traffic(input int npush, input bit rnd, output int accepted, output int launched);
    int         txt;
    int         sent;
    int         guard;
    bit         we;
    bit         busy;
    bit         done;
    logic [7:0] d;
    logic [7:0] acc[$];
    logic [7:0] got[$];
    txt = -1; sent = 0; guard = 0;
    while ((sent < npush || q.size() > 0 || phase != 0 || txt >= 0) && guard < 4000) begin
      done = 1'b0;
      if (txt > 0) txt--;
      if (txt == 0) begin done = 1'b1; txt = -1; end
      if (rnd && phase != 2 && $urandom_range(0, 7) == 0) done = 1'b1;
      we   = (sent < npush) && (!rnd || $urandom_range(0, 2) != 0);
      d    = rnd ? 8'($urandom) : 8'(sent + 1);
      busy = rnd && ($urandom_range(0, 3) == 0);
      if (we && q.size() < DEPTH) acc.push_back(d);
      cycle(we, d, busy, done);
      if (we) sent++;
      nvec++;
      if (start !== exp_start) begin nerr++; $display("FAIL traffic_start cyc=%0d got=%b want=%b", guard, start, exp_start); end
      nvec++;
      if (count !== 5'(q.size())) begin nerr++; $display("FAIL traffic_count cyc=%0d got=%0d want=%0d", guard, count, q.size()); end
      nvec++;
      if (overflow !== m_ovf) begin nerr++; $display("FAIL traffic_overflow cyc=%0d got=%b want=%b", guard, overflow, m_ovf); end
      if (exp_start) begin
        nvec++;
        if (data_out !== exp_data) begin nerr++; $display("FAIL traffic_data cyc=%0d got=%h want=%h", guard, data_out, exp_data); end
      end
      if (start) begin
        got.push_back(data_out);
        txt = rnd ? int'($urandom_range(2, 20)) : 10;
      end
      guard++;
    end
    nvec++;
    if (guard >= 4000) begin nerr++; $display("FAIL traffic_drain_timeout got=%0d cycles want<4000", guard); end
    nvec++;
    if (got.size() != acc.size()) begin nerr++; $display("FAIL traffic_byte_total got=%0d want=%0d", got.size(), acc.size()); end
    for (int i = 0; i < acc.size() && i < got.size(); i++) begin
      nvec++;
      if (got[i] !== acc[i]) begin nerr++; $display("FAIL traffic_order idx=%0d got=%h want=%h", i, got[i], acc[i]); end
    end
    accepted = acc.size();
    launched = got.size();
  endtask

  task automatic test_reset();
    do_reset(5, 1'b1);
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL reset_count got=%0d want=0", count); end
    nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL reset_empty got=%b want=1", empty); end
    nvec++; if (full !== 1'b0) begin nerr++; $display("FAIL reset_full got=%b want=0", full); end
    nvec++; if (start !== 1'b0) begin nerr++; $display("FAIL reset_start got=%b want=0", start); end
    nvec++; if (data_out !== 8'h00) begin nerr++; $display("FAIL reset_data got=%h want=00", data_out); end
    nvec++; if (overflow !== 1'b0 || tx_err !== 1'b0) begin nerr++; $display("FAIL reset_flags got=%b%b want=00", overflow, tx_err); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    nvec++; if (count !== 5'd0 || start !== 1'b0) begin nerr++; $display("FAIL reset_no_push got=%0d/%b want=0/0", count, start); end
  endtask

  task automatic test_single_byte();
    int pulses;
    do_reset(2, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    nvec++; if (start !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin nerr++; $display("FAIL single_push got=%b/%0d/%b want=0/1/0", start, count, empty); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    nvec++; if (start !== 1'b1 || data_out !== 8'hFF) begin nerr++; $display("FAIL single_launch got=%b/%h want=1/ff", start, data_out); end
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL single_popcount got=%0d want=0", count); end
    pulses = 0;
    repeat (99) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (start) pulses++;
    end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL single_extra_start got=%0d want=0", pulses); end
    nvec++; if (data_out !== 8'hFF) begin nerr++; $display("FAIL single_data_hold got=%h want=ff", data_out); end
    cycle(1'b1, 8'h3C, 1'b0, 1'b1);
    nvec++; if (start !== 1'b0 || count !== 5'd1) begin nerr++; $display("FAIL single_done got=%b/%0d want=0/1", start, count); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    nvec++; if (start !== 1'b1 || data_out !== 8'h3C) begin nerr++; $display("FAIL single_idle_after_done got=%b/%h want=1/3c", start, data_out); end
  endtask

  task automatic test_order_wrap();
    int acc_n;
    int got_n;
    do_reset(2, 1'b0);
    drive_traffic(20, 1'b0, acc_n, got_n);
    nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL order_overflow got=%b want=1", overflow); end
    nvec++; if (got_n >= 20) begin nerr++; $display("FAIL order_dropped got=%0d launched want<20", got_n); end
  endtask

  task automatic test_full_pop();
    do_reset(2, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    nvec++; if (full !== 1'b1 || count !== 5'd16 || start !== 1'b0) begin nerr++; $display("FAIL fill got=%b/%0d/%b want=1/16/0", full, count, start); end
    nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL fill_overflow got=%b want=0", overflow); end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    nvec++; if (start !== 1'b1 || data_out !== 8'h40) begin nerr++; $display("FAIL fullpop_launch got=%b/%h want=1/40", start, data_out); end
    nvec++; if (overflow !== 1'b1 || count !== 5'd15 || full !== 1'b0) begin nerr++; $display("FAIL fullpop_drop got=%b/%0d/%b want=1/15/0", overflow, count, full); end
  endtask

  task automatic test_watchdog();
    do_reset(2, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    nvec++; if (start2 !== 1'b1 || data_out2 !== 8'h5A) begin nerr++; $display("FAIL wd_launch got=%b/%h want=1/5a", start2, data_out2); end
    for (int k = 1; k <= 52; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (k == 50 || k == 51) begin
        nvec++;
        if (tx_err2 !== (k == 51)) begin nerr++; $display("FAIL wd_tx_err k=%0d got=%b want=%b", k, tx_err2, k == 51); end
      end
      nvec++;
      if (start2 !== (k == 52)) begin nerr++; $display("FAIL wd_start k=%0d got=%b want=%b", k, start2, k == 52); end
    end
    nvec++; if (data_out2 !== 8'hC3 || count2 !== 5'd0) begin nerr++; $display("FAIL wd_next_byte got=%h/%0d want=c3/0", data_out2, count2); end
  endtask

  task automatic test_stall_reset();
    int pulses;
    do_reset(2, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h21 + i), 1'b1, 1'b0);
    pulses = 0;
    repeat (10) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (start) pulses++;
    end
    nvec++; if (pulses != 0 || count !== 5'd3) begin nerr++; $display("FAIL stall got=%0d starts/%0d want=0/3", pulses, count); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    nvec++; if (start !== 1'b1 || data_out !== 8'h21) begin nerr++; $display("FAIL stall_release got=%b/%h want=1/21", start, data_out); end
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset(1, 1'b0);
    nvec++; if (start !== 1'b0 || data_out !== 8'h00 || count !== 5'd0 || empty !== 1'b1) begin nerr++; $display("FAIL midframe_reset got=%b/%h/%0d/%b want=0/00/0/1", start, data_out, count, empty); end
    nvec++; if (overflow !== 1'b0 || tx_err !== 1'b0 || full !== 1'b0) begin nerr++; $display("FAIL midframe_reset_flags got=%b%b%b want=000", overflow, tx_err, full); end
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    nvec++; if (start !== 1'b0 || count !== 5'd0) begin nerr++; $display("FAIL queued_lost got=%b/%0d want=0/0", start, count); end
  endtask

  task automatic test_random();
    int acc_n;
    int got_n;
    do_reset(2, 1'b0);
    drive_traffic(80, 1'b1, acc_n, got_n);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_order_wrap();
    test_full_pop();
    test_watchdog();
    test_stall_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=expired want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
